// File: rtl/alu_cc_pipe.sv
// Purpose : two-stage pipelined Y86 ALU (add/sub/and/xor with signed overflow) plus ZF/SF/OF register and jXX/cmovXX condition evaluation.
// Latency : op accepted at edge N is presented on out_* after edge N+1; 1 op/cycle when out_ready stays high.
// Backpr. : S1 holds while out_valid && !out_ready; S0 holds behind it; in_ready = !S0.valid || S1 can advance (comb path from out_ready).
// Ports   : clk/rst_n (async active-low), flush (sync clear), in_* operand handshake, out_* result handshake,
//           cc = {ZF,SF,OF}, cond_fn selects the Y86 condition, cond_true is its combinational result.
module alu_cc_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_ctrl,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ans,
    output logic             out_overflow,
    output logic [2:0]       cc,
    input  logic [2:0]       cond_fn,
    output logic             cond_true
);

    localparam int MSB = WIDTH - 1;

    // Stage 0: latched operands
    logic             s0_valid;
    logic [1:0]       s0_ctrl;
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;
    logic             s0_set_cc;

    logic             adv0;
    logic             adv1;
    logic [WIDTH-1:0] alu_ans;
    logic             alu_of;

    assign adv1     = s0_valid && (!out_valid || out_ready);
    assign in_ready = !s0_valid || adv1;
    // A flush edge drops whatever is offered that cycle.
    assign adv0     = in_valid && in_ready && !flush;

    // ALU operates on S0 contents; its result is captured into S1.
    always_comb begin
        alu_ans = '0;
        alu_of  = 1'b0;
        case (s0_ctrl)
            2'b00: begin
                alu_ans = s0_a + s0_b;
                alu_of  = (s0_a[MSB] == s0_b[MSB]) && (alu_ans[MSB] != s0_a[MSB]);
            end
            2'b01: begin
                alu_ans = s0_a - s0_b;
                alu_of  = (s0_a[MSB] != s0_b[MSB]) && (alu_ans[MSB] != s0_a[MSB]);
            end
            2'b10: alu_ans = s0_a & s0_b;
            default: alu_ans = s0_a ^ s0_b;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid  <= 1'b0;
            s0_ctrl   <= 2'b00;
            s0_a      <= '0;
            s0_b      <= '0;
            s0_set_cc <= 1'b0;
        end else if (flush) begin
            s0_valid <= 1'b0;
        end else if (adv0) begin
            s0_valid  <= 1'b1;
            s0_ctrl   <= in_ctrl;
            s0_a      <= in_a;
            s0_b      <= in_b;
            s0_set_cc <= in_set_cc;
        end else if (adv1) begin
            s0_valid <= 1'b0;
        end
    end

    // Stage 1 and the condition codes. The CC write is tied to the S1 load,
    // so the flags describe the result on out_ans in the same cycle. The
    // op's set_cc is consumed here rather than carried into S1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_ans      <= '0;
            out_overflow <= 1'b0;
            cc           <= 3'b100;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv1) begin
            out_valid    <= 1'b1;
            out_ans      <= alu_ans;
            out_overflow <= alu_of;
            if (s0_set_cc) begin
                cc <= {alu_ans == '0, alu_ans[MSB], alu_of};
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Y86 condition evaluation from the registered flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond_fn)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = (cc[1] ^ cc[0]) | cc[2];
            3'd2: cond_true = cc[1] ^ cc[0];
            3'd3: cond_true = cc[2];
            3'd4: cond_true = !cc[2];
            3'd5: cond_true = !(cc[1] ^ cc[0]);
            3'd6: cond_true = !(cc[1] ^ cc[0]) && !cc[2];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_cc_pipe.sv
// Purpose : self-checking bench for alu_cc_pipe (WIDTH=64) with a queue scoreboard and a monitor.
// Latency : expected results are pushed when an op is accepted and popped when the result is consumed.
// Backpr. : out_ready is forced high, forced low or randomised by a dedicated driver process.
module tb_alu_cc_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_set_cc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_ans;
    logic        out_overflow;
    logic [2:0]  cc;
    logic [2:0]  cond_fn;
    logic        cond_true;

    alu_cc_pipe #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ans(out_ans), .out_overflow(out_overflow),
        .cc(cc), .cond_fn(cond_fn), .cond_true(cond_true)
    );

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] ans;
        logic        of;
        logic        sc;
    } exp_t;

    exp_t        sbq[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          ready_mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    logic [2:0]  model_cc = 3'b100;
    logic [63:0] last_ans = '0;
    logic        last_of = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: exact signed arithmetic in 66 bits, overflow = result does not fit.
    function automatic exp_t model(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b,
                                   input logic sc);
        exp_t e;
        logic signed [65:0] sa, sb, t;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        e.sc = sc;
        e.of = 1'b0;
        case (c)
            2'd0: begin t = sa + sb; e.ans = t[63:0]; e.of = (t != {{2{e.ans[63]}}, e.ans}); end
            2'd1: begin t = sa - sb; e.ans = t[63:0]; e.of = (t != {{2{e.ans[63]}}, e.ans}); end
            2'd2: e.ans = a & b;
            default: e.ans = a ^ b;
        endcase
        return e;
    endfunction

    function automatic logic [2:0] flags_of(input exp_t e);
        return {e.ans == 64'd0, $signed(e.ans) < 0, e.of};
    endfunction

    function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] fn);
        logic zf, lt;
        zf = c[2];
        lt = (c[1] != c[0]);
        case (fn)
            3'd0: return 1'b1;
            3'd1: return lt || zf;
            3'd2: return lt;
            3'd3: return zf;
            3'd4: return !zf;
            3'd5: return !lt;
            3'd6: return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Monitor: compares every presented result against the queue head.
    initial begin : monitor
        exp_t       e;
        logic [2:0] ecc;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                sbq.delete();
                model_cc = 3'b100;
            end else begin
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_out_valid", out_valid, 1'b0);
                    end else begin
                        e   = sbq[0];
                        ecc = e.sc ? flags_of(e) : model_cc;
                        check("out_ans", out_ans, e.ans);
                        check("out_overflow", out_overflow, e.of);
                        check("cc", cc, ecc);
                        check("cond_true", cond_true, cond_ref(ecc, cond_fn));
                        if (out_ready) begin
                            void'(sbq.pop_front());
                            model_cc = ecc;
                            last_ans = e.ans;
                            last_of  = e.of;
                            pop_cnt++;
                        end
                    end
                end
                if (flush) begin
                    // An op sitting in S1 already wrote cc when it loaded.
                    if (out_valid && !out_ready && sbq.size() > 0 && sbq[0].sc)
                        model_cc = flags_of(sbq[0]);
                    sbq.delete();
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b, input logic sc);
        int budget = 300;
        bit ok = 0;
        in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b; in_set_cc = sc;
        while (!ok && budget > 0) begin
            @(negedge clk);
            if (in_ready && !flush) ok = 1;
            else begin
                @(posedge clk);
                #1;
                budget--;
            end
        end
        if (ok) begin
            @(posedge clk);
            sbq.push_back(model(c, a, b, sc));
            acc_cnt++;
            #1;
        end else begin
            check("send_timeout_in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 300;
        while ((sbq.size() > 0 || out_valid) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) check("drain_timeout_queue", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic cond_chk(input string name, input logic [2:0] fn, input logic exp);
        cond_fn = fn;
        #1;
        check(name, cond_true, exp);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return MAXP;
            2: return MINN;
            3: return '1;
            4: return 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin : stim
        int p0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = 2'd0;
        in_a = '0; in_b = '0; in_set_cc = 1'b0; cond_fn = 3'd0;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ans", out_ans, 64'd0);
        check("rst_out_overflow", out_overflow, 1'b0);
        check("rst_cc", cc, 3'b100);
        check("rst_in_ready", in_ready, 1'b1);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Overflow corner cases
        send(2'd0, MAXP, MAXP, 1'b1);
        drain();
        check("add_max_ans", last_ans, 64'hFFFF_FFFF_FFFF_FFFE);
        check("add_max_of", last_of, 1'b1);
        check("add_max_cc", cc, 3'b011);
        cond_chk("add_max_cond_l", 3'd2, 1'b0);
        cond_chk("add_max_cond_le", 3'd1, 1'b0);

        send(2'd0, MINN, MINN, 1'b1);
        drain();
        check("add_min_ans", last_ans, 64'd0);
        check("add_min_of", last_of, 1'b1);
        check("add_min_cc", cc, 3'b101);
        cond_chk("add_min_cond_e", 3'd3, 1'b1);

        send(2'd1, MAXP, MINN, 1'b0);
        drain();
        check("sub_a_ans", last_ans, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_a_of", last_of, 1'b1);
        send(2'd1, MINN, MAXP, 1'b0);
        drain();
        check("sub_b_ans", last_ans, 64'd1);
        check("sub_b_of", last_of, 1'b1);
        send(2'd3, 64'h5A, 64'h5A, 1'b0);
        drain();
        check("xor_ans", last_ans, 64'd0);
        check("xor_of", last_of, 1'b0);

        // Backpressure: 4 adds with the consumer stalled
        ready_mode = 1;
        @(posedge clk); #1;
        acc_cnt = 0;
        p0 = pop_cnt;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(2'd0, 64'(i), 64'(i), 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_accepts", acc_cnt, 2);
                check("bp_in_ready", in_ready, 1'b0);
                check("bp_out_valid", out_valid, 1'b1);
                check("bp_hold_ans", out_ans, 64'd2);
                ready_mode = 0;
            end
        join
        drain();
        check("bp_pop_count", pop_cnt - p0, 4);
        check("bp_last_ans", last_ans, 64'd8);

        // CC gating
        send(2'd1, 64'd7, 64'd7, 1'b1);
        send(2'd0, 64'd0, -64'sd5, 1'b0);
        drain();
        check("gate_last_ans", last_ans, 64'hFFFF_FFFF_FFFF_FFFB);
        check("gate_cc", cc, 3'b100);
        cond_chk("gate_cond_ne", 3'd4, 1'b0);

        // Asynchronous reset with both stages full
        ready_mode = 1;
        @(posedge clk); #1;
        send(2'd0, 64'd1, 64'd1, 1'b1);
        send(2'd0, 64'd2, 64'd2, 1'b1);
        check("prerst_cc", cc, 3'b000);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_cc", cc, 3'b100);
        check("arst_out_ans", out_ans, 64'd0);
        check("arst_in_ready", in_ready, 1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Flush with both stages full and a set_cc op in S0
        send(2'd0, 64'd5, -64'sd10, 1'b1);
        send(2'd3, 64'h5A, 64'h5A, 1'b1);
        check("preflush_cc", cc, 3'b010);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_cc", cc, 3'b010);
        check("flush_in_ready", in_ready, 1'b1);
        ready_mode = 0;
        @(posedge clk); #1;
        check("flush_stays_empty", out_valid, 1'b0);

        // Randomised traffic with random consumer stalls
        ready_mode = 2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            cond_fn = 3'($urandom_range(0, 7));
            send(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
        end
        ready_mode = 0;
        drain();
        check("final_queue_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
